// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the in-order RISC-V core.
//   fetch_state_t : fetch stage FSM states (RUN, DRAIN, FAULT)
//   NOP_INSTR     : bubble encoding, addi x0,x0,0
//   INSTR_BYTES   : size of one instruction word in bytes
//   pc_legal()    : word-aligned and fully inside instruction memory; also used
//                   by EX to check branch/jump targets early.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  // An aligned PC never overflows on +3, so the 64-bit compare is exact.
  function automatic logic pc_legal(input logic [63:0] pc, input logic [63:0] mem_size);
    return (pc[1:0] == 2'b00) && ((pc + 64'd3) <= (mem_size - 64'd1));
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational big-endian
// instruction memory and fills the IF/ID pipeline register.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   imem_addr    : byte address to instruction memory (current PC)
//   imem_instr   : instruction word for imem_addr (combinational)
//   stall        : hold PC and IF/ID (hazard unit)
//   redirect     : taken branch/jump from EX
//   redirect_pc  : redirect target
//   if_id_pc     : PC of the instruction held in IF/ID
//   if_id_instr  : instruction held in IF/ID
//   if_id_valid  : IF/ID holds a real instruction
//   halted       : fetch is draining (end of program)
//   fault        : illegal redirect target taken; sticky until reset
//   fetch_count  : valid instructions delivered to IF/ID, wraps mod 2^32
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'd4095
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= 64'h0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    count_d    = count_q;

    case (state_q)
      RUN: begin
        if (redirect) begin
          // Redirect overrides stall: the wrong-path word is squashed.
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
          if (pc_legal(redirect_pc, MEM_SIZE)) begin
            pc_d = redirect_pc;
          end else begin
            state_d = FAULT;
          end
        end else if (!stall) begin
          // A zero word marks unfilled memory, i.e. the end of the program.
          if (!pc_legal(pc_q, MEM_SIZE) || (imem_instr == 32'h0)) begin
            state_d    = DRAIN;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_instr;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 64'(INSTR_BYTES);
            count_d    = count_q + 32'd1;
          end
        end
      end
      DRAIN: begin
        // Drain may be a wrong-path artefact, so a legal redirect recovers.
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        if (redirect) begin
          if (pc_legal(redirect_pc, MEM_SIZE)) begin
            state_d = RUN;
            pc_d    = redirect_pc;
          end else begin
            state_d = FAULT;
          end
        end
      end
      default: begin
        // FAULT (and the unused encoding) absorb until reset.
        state_d    = FAULT;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_instr = if_instr_q;
  assign if_id_valid = if_valid_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == DRAIN);
  assign fault       = (state_q == FAULT);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the in-order RISC-V pipeline. Owns the program counter and drives the byte address into the combinational, big-endian `instruction_memory`. Captures the returned 32-bit word into the IF/ID pipeline register. Handles decode stalls, branch/jump redirects from EX, end-of-program draining and misaligned-target faults.

## Interface
- `RESET_PC`, 64'h0: PC loaded on reset.
- `MEM_SIZE`, 4095: instruction memory size in bytes; must match `instruction_memory`.
- `NOP_INSTR`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) clears state immediately.
- `imem_addr`  out  64  byte address to instruction memory; equals current PC.
- `imem_instr`  in  32  instruction word returned combinationally for `imem_addr`.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `redirect`  in  1  EX: taken branch/jump; replace PC.
- `redirect_pc`  in  64  redirect target.
- `if_id_pc`  out  64  PC of the instruction in IF/ID.
- `if_id_instr`  out  32  instruction in IF/ID.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch is in DRAIN.
- `fault`  out  1  misaligned or out-of-range redirect taken; sticky.
- `fetch_count`  out  32  count of valid instructions delivered to IF/ID; wraps modulo 2^32.

## Operation
- **State machine:** RUN, DRAIN, FAULT. `imem_addr = pc` in all states.
- **Address legality:** a PC is legal iff `pc[1:0] == 0` and `pc + 3 <= MEM_SIZE - 1`.
- **RUN, evaluated in priority order each edge:**
  1. **`redirect`:**
     - Legal `redirect_pc`: `pc <= redirect_pc`, IF/ID <= bubble (`valid=0`, `instr=NOP_INSTR`, `pc` unchanged), stay RUN.
     - Illegal `redirect_pc`: go FAULT, IF/ID <= bubble, `pc` unchanged.
     - `redirect` wins over `stall`.
  2. **`stall`:** `pc`, IF/ID and `fetch_count` hold.
  3. **`pc` illegal, or `imem_instr == 32'h0` (unfilled memory):** go DRAIN, IF/ID <= bubble, `pc` holds.
  4. **Otherwise:** IF/ID <= {`pc`, `imem_instr`, valid=1}, `pc <= pc + 4`, `fetch_count++`.
- **DRAIN** (end of program; possibly wrong-path, so recoverable):
  - IF/ID <= bubble every edge; `stall` is ignored.
  - Legal `redirect` → RUN with `pc <= redirect_pc`.
  - Illegal `redirect` → FAULT.
- **FAULT:** absorbing until reset. IF/ID <= bubble every edge. `redirect` and `stall` are ignored.
- **Outputs:** `halted = (state == DRAIN)`, `fault = (state == FAULT)`; both registered state decodes.
- **Arithmetic:** 64-bit unsigned; `pc + 4` wraps silently, and the wrapped value is caught by the legality check.
- **Reset values:** `pc = RESET_PC`, state RUN, `if_id_pc = 0`, `if_id_instr = NOP_INSTR`, `if_id_valid = 0`, `halted = 0`, `fault = 0`, `fetch_count = 0`.

## Timing
- Memory read is combinational: the instruction at `pc` is captured at the same edge, so PC→IF/ID latency is 1 cycle.
- **Redirect asserted before edge N:**
  - Edge N: bubble in IF/ID.
  - Edge N+1: target instruction valid in IF/ID (absent stall).
  - Redirect costs exactly one bubble from fetch.
- `stall` held k cycles freezes IF/ID for k edges. No instruction is lost or duplicated.
- `redirect` and `stall` in the same cycle: redirect applies and the stall is dropped for that edge.
- Reset asserted mid-operation: all registers take reset values asynchronously. First fetch is at `RESET_PC` on the first edge after deassertion.
- `halted`/`fault` assert one edge after the triggering condition.

## Structure
- **Shared pipeline package holds:**
  - `fetch_state_t` enum {RUN, DRAIN, FAULT}
  - `NOP_INSTR` constant
  - `INSTR_BYTES = 4`
  - function `pc_legal(pc, mem_size)`, reused by EX for early target checks
- No sub-module. PC register, FSM and IF/ID register live in one module, 150–250 lines.

## Test plan
- **Reset, then straight-line fetch:** memory holds 3 non-zero words at 0,4,8.
  - IF/ID shows pc 0,4,8 with valid=1 on consecutive edges.
  - `fetch_count` = 3.
  - Next edge: `halted` = 1 (word at 12 is 0).
- **Stall:** assert `stall` 2 cycles while pc=4 → IF/ID holds pc 0 for 2 edges; then pc 4 is delivered once.
- **Redirect:**
  - `redirect_pc = 0x40` while `stall` = 1 → bubble (valid=0, instr 0x00000013), then pc 0x40 valid.
  - `fetch_count` does not count the bubble.
- **DRAIN recovery:** in DRAIN, `redirect_pc = 0x8` → `halted` drops; fetch resumes at 0x8.
- **Faults:**
  - `redirect_pc = 0x6` → `fault` = 1, IF/ID bubbles forever, later redirects ignored.
  - `redirect_pc = 4092` with `MEM_SIZE` = 4095 → `fault` = 1.
- **Async reset mid-run:** pull `reset` low between edges → outputs reach reset values before the next edge; fetch restarts at `RESET_PC`.
